// File: rtl/fwperiph_dma_dbg_pkg.sv
// -----------------------------------------------------------------------------
// fwperiph_dma_dbg_pkg
// Shared widths and the debug-event record type for the DMA debug-event
// source and its FIFO.
//
// Optional feature macro: FWPERIPH_DMA_DBG_SRC_TS_EN. When defined, every event
// also carries a 32-bit timestamp field.
// -----------------------------------------------------------------------------
package fwperiph_dma_dbg_pkg;

  localparam int DBG_ADR_W = 32;
  localparam int DBG_DAT_W = 32;
  localparam int DBG_WE_W  = 32;
  localparam int DBG_BE_W  = 4;
  localparam int DBG_CH_W  = 5;
  localparam int DBG_TS_W  = 32;

  // One captured channel event, as it sits in the FIFO.
  typedef struct packed {
    logic [DBG_ADR_W-1:0] adr;
    logic [DBG_DAT_W-1:0] dat;
    logic [DBG_BE_W-1:0]  be;
    logic [DBG_CH_W-1:0]  ch;
`ifdef FWPERIPH_DMA_DBG_SRC_TS_EN
    logic [DBG_TS_W-1:0]  ts;
`endif
  } dbg_ev_t;

  // The stream write-enable word carries the byte enables in its low nibble
  // and zeros everywhere else.
  function automatic logic [DBG_WE_W-1:0] be_to_we(input logic [DBG_BE_W-1:0] be);
    return {{(DBG_WE_W - DBG_BE_W){1'b0}}, be};
  endfunction

endpackage

// File: rtl/fwperiph_dma_dbg_src_if.sv
// -----------------------------------------------------------------------------
// fwperiph_dma_dbg_src_if
// Bundles the per-channel event handshake (channel engines -> source) and the
// dbg_* stream plus status (source -> debug monitor).
//
// Modports:
//   master : environment side; drives channel events/activity, observes the
//            grant and the debug stream.
//   slave  : the event source itself.
//
// Signals:
//   ch_ev_valid/ready  per-channel handshake, ready is a one-hot grant
//   ch_ev_adr/dat/be   per-channel event payload, channel c at slice c
//   ch_active          per-channel transfer-in-progress
//   dbg_adr/dat_w/we   stream beat; dbg_we != 0 marks a visible beat
//   dbg_ch_sel         originating channel of the beat
//   dbg_busy           aggregate busy
//   dbg_done_all       one-cycle pulse when all activity has finished
//   dbg_ts             beat timestamp (only with FWPERIPH_DMA_DBG_SRC_TS_EN)
// -----------------------------------------------------------------------------
interface fwperiph_dma_dbg_src_if
  import fwperiph_dma_dbg_pkg::*;
#(
  parameter int ch_count = 1
) ();

  logic [ch_count-1:0]           ch_ev_valid;
  logic [ch_count-1:0]           ch_ev_ready;
  logic [DBG_ADR_W*ch_count-1:0] ch_ev_adr;
  logic [DBG_DAT_W*ch_count-1:0] ch_ev_dat;
  logic [DBG_BE_W*ch_count-1:0]  ch_ev_be;
  logic [ch_count-1:0]           ch_active;

  logic [DBG_ADR_W-1:0]          dbg_adr;
  logic [DBG_DAT_W-1:0]          dbg_dat_w;
  logic [DBG_WE_W-1:0]           dbg_we;
  logic [DBG_CH_W-1:0]           dbg_ch_sel;
  logic                          dbg_busy;
  logic                          dbg_done_all;
`ifdef FWPERIPH_DMA_DBG_SRC_TS_EN
  logic [DBG_TS_W-1:0]           dbg_ts;
`endif

  modport master (
    output ch_ev_valid, ch_ev_adr, ch_ev_dat, ch_ev_be, ch_active,
    input  ch_ev_ready,
    input  dbg_adr, dbg_dat_w, dbg_we, dbg_ch_sel, dbg_busy, dbg_done_all
`ifdef FWPERIPH_DMA_DBG_SRC_TS_EN
    , input dbg_ts
`endif
  );

  modport slave (
    input  ch_ev_valid, ch_ev_adr, ch_ev_dat, ch_ev_be, ch_active,
    output ch_ev_ready,
    output dbg_adr, dbg_dat_w, dbg_we, dbg_ch_sel, dbg_busy, dbg_done_all
`ifdef FWPERIPH_DMA_DBG_SRC_TS_EN
    , output dbg_ts
`endif
  );

endinterface

// File: rtl/fwperiph_dma_dbg_fifo.sv
// -----------------------------------------------------------------------------
// fwperiph_dma_dbg_fifo
// Synchronous FIFO of dbg_ev_t records. Read data is the head entry,
// presented combinationally; pop consumes it at the next rising edge.
// A push while full is honoured only when a pop happens in the same cycle.
//
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   push, wr_data enqueue request and record
//   pop, rd_data  dequeue request and head record
//   full, empty   registered occupancy flags
//   count         current number of entries, 0..depth
// -----------------------------------------------------------------------------
module fwperiph_dma_dbg_fifo
  import fwperiph_dma_dbg_pkg::*;
#(
  parameter int depth = 8,
  localparam int AW   = $clog2(depth),
  localparam int CW   = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  dbg_ev_t       wr_data,
  input  logic          pop,
  output dbg_ev_t       rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  dbg_ev_t       mem_q [depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // NOTE: every variable assigned in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != CW'(depth)) | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CW'(depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/fwperiph_dma_dbg_src.sv
// -----------------------------------------------------------------------------
// fwperiph_dma_dbg_src
// Producer side of the DMA debug-event stream. Per-channel write events are
// arbitrated round-robin, queued in a FIFO and replayed one per cycle on the
// dbg_* stream, together with aggregate busy and an all-done pulse.
//
// Parameters:
//   ch_count    number of DMA channels, 1..32
//   fifo_depth  event FIFO entries, power of two, >= 2
//
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   bus           fwperiph_dma_dbg_src_if.slave: channel handshakes in,
//                 dbg_* stream and status out
//
// Optional feature macro: FWPERIPH_DMA_DBG_SRC_TS_EN adds a free-running
// 32-bit cycle counter, stamps each event with the counter value at its accept
// edge, and presents the stamp on dbg_ts with the beat.
// -----------------------------------------------------------------------------
module fwperiph_dma_dbg_src
  import fwperiph_dma_dbg_pkg::*;
#(
  parameter int ch_count   = 1,
  parameter int fifo_depth = 8
) (
  input logic                   clock,
  input logic                   reset,
  fwperiph_dma_dbg_src_if.slave bus
);

  localparam int CNT_W = $clog2(fifo_depth) + 1;
  // One extra bit so rr_ptr + offset never overflows before the wrap.
  localparam int IDX_W = DBG_CH_W + 1;

  // Arbiter
  logic [31:0]          valid_ext;
  logic                 gnt_vld;
  logic [DBG_CH_W-1:0]  gnt_idx;
  logic [IDX_W-1:0]     scan_idx;
  logic [IDX_W-1:0]     rr_nxt;
  logic [ch_count-1:0]  ch_ready;
  logic [DBG_CH_W-1:0]  rr_ptr_q, rr_ptr_d;

  // FIFO
  dbg_ev_t              ev_in, ev_out;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0]     fifo_count;

  // Output stream and status
  logic [DBG_ADR_W-1:0] adr_q, adr_d;
  logic [DBG_DAT_W-1:0] dat_q, dat_d;
  logic [DBG_WE_W-1:0]  we_q, we_d;
  logic [DBG_CH_W-1:0]  ch_q, ch_d;
  logic                 busy_q, busy_d;
  logic                 busy_hist_q, busy_hist_d;
  logic                 done_q, done_d;

`ifdef FWPERIPH_DMA_DBG_SRC_TS_EN
  logic [DBG_TS_W-1:0]  ts_cnt_q, ts_cnt_d;
  logic [DBG_TS_W-1:0]  ts_q, ts_d;
`endif

  // Round-robin scan: first valid channel at or after rr_ptr, wrapping. The
  // grant looks only at the registered full flag, so a full FIFO stalls the
  // arbiter for a cycle even if the head is being drained.
  always_comb begin
    valid_ext = 32'(bus.ch_ev_valid);
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    if (!reset && !fifo_full) begin
      for (int i = 0; i < ch_count; i++) begin
        scan_idx = {1'b0, rr_ptr_q} + IDX_W'(i);
        if (scan_idx >= IDX_W'(ch_count)) begin
          scan_idx = scan_idx - IDX_W'(ch_count);
        end
        if (!gnt_vld && valid_ext[scan_idx[DBG_CH_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = scan_idx[DBG_CH_W-1:0];
        end
      end
    end
  end

  // One-hot ready and payload selection for the granted channel.
  always_comb begin
    ch_ready = '0;
    ev_in    = '0;
    for (int c = 0; c < ch_count; c++) begin
      if (gnt_vld && (gnt_idx == DBG_CH_W'(c))) begin
        ch_ready[c] = 1'b1;
        ev_in.adr   = bus.ch_ev_adr[c*DBG_ADR_W +: DBG_ADR_W];
        ev_in.dat   = bus.ch_ev_dat[c*DBG_DAT_W +: DBG_DAT_W];
        ev_in.be    = bus.ch_ev_be[c*DBG_BE_W +: DBG_BE_W];
      end
    end
    ev_in.ch = gnt_idx;
`ifdef FWPERIPH_DMA_DBG_SRC_TS_EN
    ev_in.ts = ts_cnt_q;
`endif
  end

  // The pointer only moves on an accept; with a single channel the wrap keeps
  // it at 0.
  always_comb begin
    rr_nxt = {1'b0, gnt_idx} + IDX_W'(1);
    if (rr_nxt >= IDX_W'(ch_count)) begin
      rr_nxt = '0;
    end
    rr_ptr_d = gnt_vld ? rr_nxt[DBG_CH_W-1:0] : rr_ptr_q;
  end

  assign bus.ch_ev_ready = ch_ready;

  fwperiph_dma_dbg_fifo #(
    .depth (fifo_depth)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (gnt_vld),
    .wr_data (ev_in),
    .pop     (fifo_pop),
    .rd_data (ev_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // The stream has no back-pressure: the head is always drained, one beat per
  // cycle. With nothing queued dbg_we drops to 0 while the payload holds.
  always_comb begin
    fifo_pop = !fifo_empty;
    adr_d    = adr_q;
    dat_d    = dat_q;
    ch_d     = ch_q;
    we_d     = '0;
`ifdef FWPERIPH_DMA_DBG_SRC_TS_EN
    ts_d     = ts_q;
    ts_cnt_d = ts_cnt_q + DBG_TS_W'(1);
`endif
    if (fifo_pop) begin
      adr_d = ev_out.adr;
      dat_d = ev_out.dat;
      ch_d  = ev_out.ch;
      we_d  = be_to_we(ev_out.be);
`ifdef FWPERIPH_DMA_DBG_SRC_TS_EN
      ts_d  = ev_out.ts;
`endif
    end

    // Busy covers active channels, queued events and a visible beat on the
    // stream. Done fires one cycle after busy falls, unless busy comes back
    // at that same edge; busy_hist starts at 0 so reset never produces it.
    busy_d      = (|bus.ch_active) | (fifo_count != '0) | (we_q != '0);
    busy_hist_d = busy_q;
    done_d      = busy_hist_q & ~busy_q & ~busy_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= '0;
      ch_q        <= '0;
      busy_q      <= 1'b0;
      busy_hist_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      ch_q        <= ch_d;
      busy_q      <= busy_d;
      busy_hist_q <= busy_hist_d;
      done_q      <= done_d;
    end
  end

`ifdef FWPERIPH_DMA_DBG_SRC_TS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      ts_q     <= ts_d;
    end
  end

  assign bus.dbg_ts = ts_q;
`endif

  assign bus.dbg_adr      = adr_q;
  assign bus.dbg_dat_w    = dat_q;
  assign bus.dbg_we       = we_q;
  assign bus.dbg_ch_sel   = ch_q;
  assign bus.dbg_busy     = busy_q;
  assign bus.dbg_done_all = done_q;

endmodule

// File: tb/tb_fwperiph_dma_dbg_src.sv
// -----------------------------------------------------------------------------
// tb_fwperiph_dma_dbg_src
// Self-checking bench for fwperiph_dma_dbg_src with four channels and an
// eight-entry FIFO. A queue-based reference model predicts grants, the beat
// sequence on the stream, busy and the all-done pulse.
// -----------------------------------------------------------------------------
module tb_fwperiph_dma_dbg_src;

  localparam int CH    = 4;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  be;
    int          ch;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fwperiph_dma_dbg_src_if #(.ch_count(CH)) bus ();

  fwperiph_dma_dbg_src #(
    .ch_count   (CH),
    .fifo_depth (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  ev_t         model_q[$];
  int          rr_m;
  logic [31:0] exp_adr, exp_dat, exp_we;
  int          exp_ch;
  logic        exp_busy, busy_h2, exp_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    rr_m     = 0;
    exp_adr  = '0;
    exp_dat  = '0;
    exp_we   = '0;
    exp_ch   = 0;
    exp_busy = 1'b0;
    busy_h2  = 1'b0;
    exp_done = 1'b0;
  endtask

  function automatic int model_grant(input logic [CH-1:0] vld);
    if (model_q.size() >= DEPTH) return -1;
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (rr_m + k) % CH;
      if (vld[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    check("dbg_we",       bus.dbg_we,               exp_we);
    check("dbg_adr",      bus.dbg_adr,              exp_adr);
    check("dbg_dat_w",    bus.dbg_dat_w,            exp_dat);
    check("dbg_ch_sel",   32'(bus.dbg_ch_sel),      32'(exp_ch));
    check("dbg_busy",     32'(bus.dbg_busy),        32'(exp_busy));
    check("dbg_done_all", 32'(bus.dbg_done_all),    32'(exp_done));
  endtask

  // One clock cycle: inputs are already driven by the caller.
  task automatic tick();
    logic [CH-1:0] vld, act;
    int   g;
    logic busy_new;
    ev_t  e, h;
    #1;
    vld = bus.ch_ev_valid;
    act = bus.ch_active;
    g   = model_grant(vld);
    check("ch_ev_ready", 32'(bus.ch_ev_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    e = '{adr: '0, dat: '0, be: '0, ch: 0};
    for (int c = 0; c < CH; c++) begin
      if (c == g) begin
        e.adr = bus.ch_ev_adr[c*32 +: 32];
        e.dat = bus.ch_ev_dat[c*32 +: 32];
        e.be  = bus.ch_ev_be[c*4 +: 4];
        e.ch  = c;
      end
    end
    @(posedge clock);
    busy_new = (|act) || (model_q.size() > 0) || (exp_we != 0);
    if (model_q.size() > 0) begin
      h       = model_q.pop_front();
      exp_adr = h.adr;
      exp_dat = h.dat;
      exp_ch  = h.ch;
      exp_we  = {28'd0, h.be};
    end else begin
      exp_we = '0;
    end
    if (g >= 0) begin
      model_q.push_back(e);
      rr_m = (g + 1) % CH;
    end
    exp_done = busy_h2 && !exp_busy && !busy_new;
    busy_h2  = exp_busy;
    exp_busy = busy_new;
    #1;
    check_outputs();
  endtask

  task automatic drive_ch(input int c, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] be);
    bus.ch_ev_valid[c]        = 1'b1;
    bus.ch_ev_adr[c*32 +: 32] = adr;
    bus.ch_ev_dat[c*32 +: 32] = dat;
    bus.ch_ev_be[c*4 +: 4]    = be;
  endtask

  task automatic idle_inputs();
    bus.ch_ev_valid = '0;
    bus.ch_active   = '0;
  endtask

  initial begin
    bus.ch_ev_valid = '1;
    bus.ch_ev_adr   = '0;
    bus.ch_ev_dat   = '0;
    bus.ch_ev_be    = '1;
    bus.ch_active   = '0;
    model_reset();

    // Reset state: all outputs zero, no grant even with every channel valid.
    #2;
    check("rst_ready", 32'(bus.ch_ev_ready), 32'd0);
    check_outputs();
    @(posedge clock);
    #1;
    idle_inputs();
    reset = 1'b0;

    // Single event from channel 1: grant, then one visible beat.
    drive_ch(1, 32'h0000_1000, 32'hA5A5_A5A5, 4'hF);
    tick();
    idle_inputs();
    tick();
    check("t1_we",     bus.dbg_we,               32'h0000_000F);
    check("t1_ch_sel", 32'(bus.dbg_ch_sel),      32'd1);
    check("t1_adr",    bus.dbg_adr,              32'h0000_1000);
    tick();
    check("t1_we_gone", bus.dbg_we,              32'd0);
    check("t1_adr_hold", bus.dbg_adr,            32'h0000_1000);
    for (int i = 0; i < 3; i++) tick();

    // All channels valid continuously: round-robin order, one beat per cycle.
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < CH; c++) drive_ch(c, $urandom(), $urandom(), 4'($urandom_range(1, 15)));
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();

    // Event with zero byte enables is consumed but leaves no visible beat.
    drive_ch(3, 32'hDEAD_0000, 32'h1234_5678, 4'h0);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();

    // Channel activity only: busy follows, then a single done pulse.
    bus.ch_active = 4'b0100;
    for (int i = 0; i < 10; i++) tick();
    bus.ch_active = '0;
    for (int i = 0; i < 5; i++) tick();

    // Reset in the middle of traffic: outputs clear at once, nothing replays.
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < CH; c++) drive_ch(c, $urandom(), $urandom(), 4'hF);
      bus.ch_active = 4'b0011;
      tick();
    end
    reset = 1'b1;
    #1;
    model_reset();
    check("mid_rst_ready", 32'(bus.ch_ev_ready), 32'd0);
    check_outputs();
    @(posedge clock);
    #1;
    check_outputs();
    idle_inputs();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Randomized traffic with sporadic channel activity.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++) begin
        bus.ch_ev_valid[c]        = ($urandom_range(0, 99) < 45);
        bus.ch_ev_adr[c*32 +: 32] = $urandom();
        bus.ch_ev_dat[c*32 +: 32] = $urandom();
        bus.ch_ev_be[c*4 +: 4]    = ($urandom_range(0, 99) < 3) ? 4'h0
                                                                 : 4'($urandom_range(1, 15));
        bus.ch_active[c]          = ($urandom_range(0, 99) < 5);
      end
      if ($urandom_range(0, 99) < 20) bus.ch_ev_valid = '0;
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
